// File: rtl/imm_gen_pipe_pkg.sv
// Shared encodings for the decode-stage immediate generator.
package imm_gen_pipe_pkg;

  localparam int unsigned SRC_W = 3;

  localparam logic [SRC_W-1:0] IMM_I = 3'd0;
  localparam logic [SRC_W-1:0] IMM_S = 3'd1;
  localparam logic [SRC_W-1:0] IMM_B = 3'd2;
  localparam logic [SRC_W-1:0] IMM_U = 3'd3;
  localparam logic [SRC_W-1:0] IMM_J = 3'd4;
  localparam logic [SRC_W-1:0] IMM_Z = 3'd5;

  localparam int unsigned XLEN_32 = 32;
  localparam int unsigned XLEN_64 = 64;

endpackage : imm_gen_pipe_pkg

// File: rtl/imm_gen_pipe_if.sv
// Input and output valid/ready streams of the immediate generator.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  // slave: the generator itself
  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );

  // master: producer/consumer wrapped around the generator
  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface : imm_gen_pipe_if

// File: rtl/imm_gen_pipe_imm_format.sv
// Combinational RV32/RV64 immediate formatter; also used by the branch-target unit.
module imm_format
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]      instr,
  input  logic [SRC_W-1:0] imm_src,
  output logic [XLEN-1:0]  imm_c,
  output logic             err_c
);

  // Each field is cast to signed so the width cast replicates its top bit.
  always_comb begin
    imm_c = '0;
    err_c = 1'b0;
    unique case (imm_src)
      IMM_I: imm_c = XLEN'(signed'(instr[31:20]));
      IMM_S: imm_c = XLEN'(signed'({instr[31:25], instr[11:7]}));
      IMM_B: imm_c = XLEN'(signed'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U: imm_c = XLEN'(signed'({instr[31:12], 12'b0}));
      IMM_J: imm_c = XLEN'(signed'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_Z: imm_c = XLEN'(instr[19:15]);
      default: begin
        imm_c = '0;
        err_c = 1'b1;
      end
    endcase
  end

endmodule : imm_format

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer and flush.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic             valid;
  } entry_t;

  entry_t          out_q, out_d;
  entry_t          skid_q, skid_d;
  entry_t          new_entry;
  logic [XLEN-1:0] fmt_imm;
  logic            fmt_err;
  logic            in_ready_c;
  logic            accept;
  logic            drain;

  imm_format #(.XLEN(XLEN)) u_imm_format (
    .instr   (bus.instr),
    .imm_src (bus.imm_src),
    .imm_c   (fmt_imm),
    .err_c   (fmt_err)
  );

  assign new_entry  = '{imm: fmt_imm, tag: bus.in_tag, err: fmt_err, valid: 1'b1};
  // Ready depends only on skid occupancy, never on out_ready.
  assign in_ready_c = !skid_q.valid && !rst;
  assign accept     = bus.in_valid && in_ready_c;
  assign drain      = out_q.valid && bus.out_ready;

  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (flush) begin
      out_d.valid  = 1'b0;
      skid_d.valid = 1'b0;
    end else if (!out_q.valid || drain) begin
      if (skid_q.valid) begin
        out_d        = skid_q;
        skid_d.valid = 1'b0;
      end else if (accept) begin
        out_d = new_entry;
      end else begin
        out_d.valid = 1'b0;
      end
    end else if (accept) begin
      skid_d = new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_q.valid;
  assign bus.out_imm   = out_q.imm;
  assign bus.out_tag   = out_q.tag;
  assign bus.out_err   = out_q.err;

endmodule : imm_gen_pipe

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: format table at XLEN 32/64 plus backpressure, flush and reset sequences.
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  logic clk;
  logic rst;
  logic flush;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] exp32;
    logic [63:0] exp64;
    logic        err;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  int checks;
  int errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [2:0] src, input logic [7:0] tag);
    b32.in_valid = v;  b32.instr = ins;  b32.imm_src = src;  b32.in_tag = tag;
    b64.in_valid = v;  b64.instr = ins;  b64.imm_src = src;  b64.in_tag = tag;
  endtask

  task automatic set_ready(input logic r);
    b32.out_ready = r;
    b64.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          nxt;
  int          expo;
  logic        acc;
  logic        stalled;
  logic [31:0] prev_imm;
  logic [7:0]  prev_tag;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{32'hFFF00093, IMM_I, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'hFE20AE23, IMM_S, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2] = '{32'h123450B7, IMM_U, 32'h12345000, 64'h0000000012345000, 1'b0};
    vecs[3] = '{32'h80000063, IMM_B, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0};
    vecs[4] = '{32'h8000006F, IMM_J, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
    vecs[5] = '{32'h000F8073, IMM_Z, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vecs[6] = '{32'hFFF00093, 3'd6,  32'h00000000, 64'h0000000000000000, 1'b1};
    vecs[7] = '{32'h7FF00093, IMM_I, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vecs[8] = '{32'h800000B7, IMM_U, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vecs[9] = '{32'h800000B7, 3'd7,  32'h00000000, 64'h0000000000000000, 1'b1};

    rst = 1'b1;
    flush = 1'b0;
    set_in(1'b1, 32'hFFF00093, IMM_I, 8'hAA);
    set_ready(1'b1);
    tick();
    tick();
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_out_imm",   64'(b32.out_imm),   64'd0);
    chk("rst_out_tag",   64'(b32.out_tag),   64'd0);
    chk("rst_out_err",   64'(b32.out_err),   64'd0);
    chk("rst_in_ready",  64'(b32.in_ready),  64'd0);

    rst = 1'b0;
    set_in(1'b0, 32'h0, IMM_I, 8'h00);
    #1;
    chk("post_rst_in_ready", 64'(b32.in_ready), 64'd1);

    // Streamed table: each result must appear exactly one cycle after its accept.
    for (int i = 0; i < NVEC; i++) begin
      set_in(1'b1, vecs[i].instr, vecs[i].src, 8'(i + 1));
      chk("tbl_in_ready", 64'(b32.in_ready), 64'd1);
      tick();
      chk($sformatf("tbl%0d_valid", i), 64'(b32.out_valid), 64'd1);
      chk($sformatf("tbl%0d_imm32", i), 64'(b32.out_imm),   64'(vecs[i].exp32));
      chk($sformatf("tbl%0d_imm64", i), b64.out_imm,        vecs[i].exp64);
      chk($sformatf("tbl%0d_err", i),   64'(b32.out_err),   64'(vecs[i].err));
      chk($sformatf("tbl%0d_tag", i),   64'(b32.out_tag),   64'(i + 1));
    end
    set_in(1'b0, 32'h0, IMM_I, 8'h00);
    tick();
    chk("tbl_drained", 64'(b32.out_valid), 64'd0);

    // Backpressure: tags 1..5, consumer stalled for the first 4 cycles.
    nxt = 1;
    expo = 1;
    stalled = 1'b0;
    prev_imm = '0;
    prev_tag = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      set_ready(cyc >= 4);
      set_in(nxt <= 5, {12'(nxt), 20'h00093}, IMM_I, 8'(nxt));
      if (stalled) begin
        chk("bp_stable_imm", 64'(b32.out_imm), 64'(prev_imm));
        chk("bp_stable_tag", 64'(b32.out_tag), 64'(prev_tag));
      end
      acc = b32.in_valid && b32.in_ready;
      if (b32.out_valid && b32.out_ready) begin
        chk("bp_order_tag", 64'(b32.out_tag), 64'(expo));
        chk("bp_order_imm", 64'(b32.out_imm), 64'(expo));
        expo++;
      end
      stalled  = b32.out_valid && !b32.out_ready;
      prev_imm = b32.out_imm;
      prev_tag = b32.out_tag;
      tick();
      if (acc) nxt++;
      if (cyc == 1) begin
        chk("bp_full_in_ready", 64'(b32.in_ready), 64'd0);
        chk("bp_full_out_tag",  64'(b32.out_tag),  64'd1);
      end
    end
    chk("bp_all_out", 64'(expo), 64'd6);
    chk("bp_empty", 64'(b32.out_valid), 64'd0);

    // Flush with both entries full and an input offered in the same cycle.
    set_ready(1'b0);
    set_in(1'b1, 32'h01000093, IMM_I, 8'h10);
    tick();
    set_in(1'b1, 32'h01100093, IMM_I, 8'h11);
    tick();
    chk("fl_full_in_ready", 64'(b32.in_ready), 64'd0);
    flush = 1'b1;
    set_in(1'b1, 32'h01200093, IMM_I, 8'h12);
    tick();
    flush = 1'b0;
    chk("fl_out_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_in_ready",  64'(b32.in_ready),  64'd1);
    set_in(1'b0, 32'h0, IMM_I, 8'h00);
    set_ready(1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl_no_ghost", 64'(b32.out_valid), 64'd0);
    end

    // Flush while only OUT is full: the same-cycle accept must be dropped.
    set_ready(1'b0);
    set_in(1'b1, 32'h01300093, IMM_I, 8'h13);
    tick();
    chk("fl1_in_ready", 64'(b32.in_ready), 64'd1);
    flush = 1'b1;
    set_in(1'b1, 32'h01400093, IMM_I, 8'h14);
    tick();
    flush = 1'b0;
    set_in(1'b0, 32'h0, IMM_I, 8'h00);
    set_ready(1'b1);
    chk("fl1_out_valid", 64'(b32.out_valid), 64'd0);
    tick();
    chk("fl1_no_ghost", 64'(b32.out_valid), 64'd0);

    // Reset while stalled with two entries, the head carrying an error.
    set_ready(1'b0);
    set_in(1'b1, 32'hFFF00093, 3'd6, 8'h21);
    tick();
    set_in(1'b1, 32'h123450B7, IMM_U, 8'h22);
    tick();
    chk("rs_pre_err",      64'(b32.out_err),  64'd1);
    chk("rs_pre_in_ready", 64'(b32.in_ready), 64'd0);
    rst = 1'b1;
    set_in(1'b1, 32'h7FF00093, IMM_I, 8'h23);
    #1;
    chk("rs_in_ready_during", 64'(b32.in_ready), 64'd0);
    tick();
    chk("rs_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rs_out_imm",   64'(b32.out_imm),   64'd0);
    chk("rs_out_tag",   64'(b32.out_tag),   64'd0);
    chk("rs_out_err",   64'(b32.out_err),   64'd0);
    chk("rs_in_ready",  64'(b32.in_ready),  64'd0);
    tick();
    rst = 1'b0;
    set_ready(1'b1);
    set_in(1'b1, 32'hFFF00093, IMM_I, 8'h33);
    #1;
    chk("rs_after_valid", 64'(b32.out_valid), 64'd0);
    chk("rs_after_ready", 64'(b32.in_ready),  64'd1);
    tick();
    set_in(1'b0, 32'h0, IMM_I, 8'h00);
    chk("rs_new_valid", 64'(b32.out_valid), 64'd1);
    chk("rs_new_tag",   64'(b32.out_tag),   64'h33);
    chk("rs_new_imm",   64'(b32.out_imm),   64'hFFFFFFFF);
    chk("rs_new_imm64", b64.out_imm,        64'hFFFFFFFFFFFFFFFF);
    tick();
    chk("rs_new_once", 64'(b32.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_imm_gen_pipe

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised immediate generator for the decode stage.
- Covers all RV32/RV64 immediate formats (I, S, B, U, J, CSR-Z). Output is sign- or zero-extended to XLEN.
- Registered output with a valid/ready handshake and a 2-entry skid buffer, so it sits between fetch/decode and execute without a combinational ready path.
- Supports pipeline flush and carries a sideband tag (e.g. rd/PC index) aligned with each immediate.

Parameters:
- XLEN, 32, output data width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag passed through with each instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  drop all buffered entries.
- in_valid  in  1  instr/imm_src/in_tag are valid.
- in_ready  out  1  block can accept an input this cycle.
- instr  in  32  raw instruction word.
- imm_src  in  3  format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z, 6-7 reserved.
- in_tag  in  TAG_W  sideband payload.
- out_valid  out  1  out_imm/out_tag/out_err are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the current output entry.
- out_err  out  1  imm_src was reserved; out_imm is 0.

Behaviour:
- Immediate formats (combinational, input side):
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25], instr[11:7]}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U = sext({instr[31:12], 12'b0}); bit 31 is replicated to XLEN-1 when XLEN=64.
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Z = zext(instr[19:15]).
  - Reserved select (6-7): imm=0, err=1.
- sext replicates the top bit of the formed field up to XLEN-1.
- Storage: an output register (OUT) and a skid register (SKID), each holding {imm, tag, err, valid}.
- in_ready = !SKID.valid && !rst. It is a registered-state-only function with no combinational path from out_ready.
- Accept = in_valid && in_ready. Drain = OUT.valid && out_ready.
- Per-cycle update, in priority order:
  1. rst: OUT.valid=0, SKID.valid=0; imm/tag/err regs cleared to 0. Inputs presented during reset are discarded.
  2. flush: both valids cleared next cycle; any accept in the same cycle is dropped; data regs may hold stale values.
  3. If OUT is empty or drained:
     - SKID.valid: OUT<=SKID, SKID.valid<=0. A simultaneous accept cannot occur because in_ready=0.
     - else if accept: OUT<=new entry.
     - else: OUT.valid<=0.
  4. Else (OUT holds and stalls): on accept, SKID<=new entry.
- Latency: 1 cycle from accept to out_valid when not stalled. Full throughput of 1/cycle while out_ready=1.
- Capacity is 2 entries. When both are full, in_ready=0 until a drain. After a drain with SKID full, in_ready returns to 1 the following cycle.
- Ordering is strictly FIFO. No entry is duplicated or lost except by flush or reset.
- Output stability: while out_valid && !out_ready, out_imm/out_tag/out_err hold constant.
- Reset mid-stall: all entries lost; out_valid=0 on the first cycle after rst falls.
- Reset values: out_valid=0, out_imm=0, out_tag=0, out_err=0; in_ready=0 during reset and 1 after.

Decomposition:
- Shared package: imm_src encodings as localparams (IMM_I=0 … IMM_Z=5) and the legal XLEN values.
- Sub-module imm_format: purely combinational {instr, imm_src} -> {imm, err} formatting, parametrised by XLEN. It is reused by the branch-target unit.
- The skid/handshake logic stays in imm_gen_pipe.

Test Plan:
- I/S/U formats, XLEN=32, out_ready=1:
  - 0xFFF00093 src=I -> 0xFFFFFFFF.
  - 0xFE20AE23 src=S -> 0xFFFFFFFC.
  - 0x123450B7 src=U -> 0x12345000.
  - Each appears one cycle after accept.
- B/J/Z formats:
  - 0x80000063 src=B -> 0xFFFFF000.
  - 0x8000006F src=J -> 0xFFF00000.
  - 0x000F8073 src=Z -> 0x0000001F.
  - src=6 -> imm 0, out_err=1.
- XLEN=64: 0x800000B7 src=U -> 0xFFFFFFFF80000000; 0x7FF00093 src=I -> 0x00000000000007FF.
- Backpressure: stream tags 1..5 with out_ready=0 for 4 cycles:
  - Tags 1 and 2 are held in OUT/SKID; in_ready drops to 0.
  - Then release: tags emerge in order 1..5, none lost or duplicated; out_imm stays stable while stalled.
- Flush with both entries full plus an in_valid input in the same cycle -> out_valid=0 next cycle, in_ready=1, and the flushed-cycle input never appears.
- Assert rst while stalled with 2 entries -> out_valid=0, all outputs 0, in_ready=0 during reset. A new input after reset is output normally with 1-cycle latency.
